// File: rtl/fft_agu_if.sv
// fft_agu_if: control, address and load-reorder signals of the FFT address generator.
interface fft_agu_if #(
  parameter int unsigned LOG_N = 9
);
  logic             start;
  logic [LOG_N-1:0] load_idx;
  logic [LOG_N-1:0] load_adr;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic             rd_bank;
  logic [LOG_N-1:0] rd_adr_a;
  logic [LOG_N-1:0] rd_adr_b;
  logic [LOG_N-2:0] twiddle_adr;
  logic             wr_en;
  logic             wr_bank;
  logic [LOG_N-1:0] wr_adr_a;
  logic [LOG_N-1:0] wr_adr_b;
  logic             result_bank;

  modport master (
    input  start, load_idx,
    output load_adr, busy, done, rd_en, rd_bank, rd_adr_a, rd_adr_b,
           twiddle_adr, wr_en, wr_bank, wr_adr_a, wr_adr_b, result_bank
  );

  modport slave (
    output start, load_idx,
    input  load_adr, busy, done, rd_en, rd_bank, rd_adr_a, rd_adr_b,
           twiddle_adr, wr_en, wr_bank, wr_adr_a, wr_adr_b, result_bank
  );
endinterface

// File: rtl/fft_agu.sv
// fft_agu: in-place radix-2 FFT sequencer and ping-pong address generator.
// Build macro FFT_AGU_BITREV_EN: when defined, load_adr is the bit-reverse of
// load_idx; otherwise load_adr follows load_idx unchanged (same latency).
module fft_agu #(
  parameter int unsigned LOG_N  = 9,
  parameter int unsigned RD_LAT = 1
) (
  input  logic      clk,
  input  logic      reset,
  fft_agu_if.master bus
);
  localparam int unsigned HALF  = 1 << (LOG_N - 1);
  localparam int unsigned J_W   = LOG_N - 1;
  localparam int unsigned STG_W = $clog2(LOG_N);
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [J_W-1:0]   j_q, j_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             done_d;
  logic             last_bfly, last_stage, lat_end;

  logic             rd_en_q, rd_bank_q, busy_q, done_q;
  logic [LOG_N-1:0] rd_a_q, rd_b_q, load_q, load_d;
  logic [J_W-1:0]   tw_q;

  logic             pipe_en   [RD_LAT];
  logic             pipe_bank [RD_LAT];
  logic [LOG_N-1:0] pipe_a    [RD_LAT];
  logic [LOG_N-1:0] pipe_b    [RD_LAT];

  // Rotate left by s within LOG_N bits.
  function automatic logic [LOG_N-1:0] rotl(input logic [LOG_N-1:0] x,
                                            input logic [STG_W-1:0] s);
    logic [2*LOG_N-1:0] w;
    w = {x, x} << s;
    return w[2*LOG_N-1:LOG_N];
  endfunction

  // Twiddle index: keep only the top 'stage' bits of j.
  function automatic logic [J_W-1:0] twid(input logic [J_W-1:0] j,
                                          input logic [STG_W-1:0] s);
    logic [J_W-1:0]   ones;
    logic [STG_W-1:0] shamt;
    ones  = '1;
    shamt = STG_W'(LOG_N - 1) - s;
    return j & (ones << shamt);
  endfunction

  assign last_bfly  = (j_q == J_W'(HALF - 1));
  assign last_stage = (stage_q == STG_W'(LOG_N - 1));
  assign lat_end    = (lat_q == LAT_W'(RD_LAT - 1));

  // State and loop counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      j_q     <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state: walk butterflies, then hold RD_LAT cycles between stages.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    lat_d   = lat_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          stage_d = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        if (last_bfly) begin
          lat_d   = '0;
          state_d = last_stage ? DRAIN : GAP;
        end else begin
          j_d = j_q + J_W'(1);
        end
      end
      GAP: begin
        if (lat_end) begin
          state_d = RUN;
          stage_d = stage_q + STG_W'(1);
          j_d     = '0;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      DRAIN: begin
        if (lat_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-side outputs registered from the next-state view so they align with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q   <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_a_q    <= '0;
      rd_b_q    <= '0;
      tw_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_en_q <= (state_d == RUN);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
      if (state_d == RUN) begin
        rd_a_q    <= rotl({j_d, 1'b0}, stage_d);
        rd_b_q    <= rotl({j_d, 1'b1}, stage_d);
        tw_q      <= twid(j_d, stage_d);
        rd_bank_q <= stage_d[0];
      end
    end
  end

  // Write-back pipeline: RD_LAT-deep delay of the read request, bank flipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_en[i]   <= 1'b0;
        pipe_bank[i] <= 1'b0;
        pipe_a[i]    <= '0;
        pipe_b[i]    <= '0;
      end
    end else begin
      pipe_en[0]   <= rd_en_q;
      pipe_bank[0] <= rd_en_q & ~rd_bank_q;
      pipe_a[0]    <= rd_a_q;
      pipe_b[0]    <= rd_b_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_bank[i] <= pipe_bank[i-1];
        pipe_a[i]    <= pipe_a[i-1];
        pipe_b[i]    <= pipe_b[i-1];
      end
    end
  end

  // Input-load address mapping.
  always_comb begin
    load_d = bus.load_idx;
`ifdef FFT_AGU_BITREV_EN
    for (int unsigned k = 0; k < LOG_N; k++) begin
      load_d[k] = bus.load_idx[LOG_N-1-k];
    end
`endif
  end

  // Load address register, active in every state.
  always_ff @(posedge clk) begin
    if (reset) load_q <= '0;
    else       load_q <= load_d;
  end

  assign bus.load_adr    = load_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.rd_adr_a    = rd_a_q;
  assign bus.rd_adr_b    = rd_b_q;
  assign bus.twiddle_adr = tw_q;
  assign bus.wr_en       = pipe_en[RD_LAT-1];
  assign bus.wr_bank     = pipe_bank[RD_LAT-1];
  assign bus.wr_adr_a    = pipe_a[RD_LAT-1];
  assign bus.wr_adr_b    = pipe_b[RD_LAT-1];
  assign bus.result_bank = 1'(LOG_N % 2);
endmodule

// File: tb/tb_fft_agu.sv
// tb_fft_agu: directed checks on LOG_N=3 and default builds, plus randomized
// start/reset/load traffic on a LOG_N=4, RD_LAT=2 instance against a schedule model.
module tb_fft_agu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, rst9, rst4;

  fft_agu_if #(.LOG_N(3)) b3 ();
  fft_agu_if #(.LOG_N(9)) b9 ();
  fft_agu_if #(.LOG_N(4)) b4 ();

  fft_agu #(.LOG_N(3), .RD_LAT(1)) dut3 (.clk(clk), .reset(rst3), .bus(b3));
  fft_agu                          dut9 (.clk(clk), .reset(rst9), .bus(b9));
  fft_agu #(.LOG_N(4), .RD_LAT(2)) dut4 (.clk(clk), .reset(rst4), .bus(b4));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int rd_en; int a; int b; int tw; int rd_bank;
    int wr_en; int wa; int wb; int wr_bank;
    int busy; int done;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rot(input int x, input int s, input int l);
    return ((x << s) | (x >> (l - s))) & ((1 << l) - 1);
  endfunction

  function automatic int ref_load(input int idx, input int l);
    int r;
    r = idx;
`ifdef FFT_AGU_BITREV_EN
    r = 0;
    for (int k = 0; k < l; k++)
      if (((idx >> k) & 1) == 1) r = r | (1 << (l - 1 - k));
`endif
    return r;
  endfunction

  // Position t (1-based cycle within a transform) -> read activity, butterfly, stage.
  localparam int L4 = 4, LAT4 = 2, H4 = 8, P4 = H4 + LAT4, T4 = L4 * P4;
  function automatic void sched(input int t, output int en, output int j, output int s);
    en = 0; j = 0; s = 0;
    if (t >= 1) begin
      s  = (t - 1) / P4;
      j  = (t - 1) % P4;
      en = (j < H4) ? 1 : 0;
    end
  endfunction

  int ti, ndone, dcyc, nbusy, nwr;
  int rt, exp_done, exp_load, p_start, p_rst, p_idx;
  int en, j, s, ja;

  initial begin
    // Expected LOG_N=3, RD_LAT=1 timeline; -1 marks fields not checked on that cycle.
    tbl.push_back('{1,  1, 0, 1, 0, 0,   0, -1, -1, -1,  1, 0});
    tbl.push_back('{2,  1, 2, 3, 0, 0,   1,  0,  1,  1,  1, 0});
    tbl.push_back('{5,  0,-1,-1,-1,-1,   1,  6,  7,  1,  1, 0});
    tbl.push_back('{6,  1, 0, 2, 0, 1,   0, -1, -1, -1,  1, 0});
    tbl.push_back('{7,  1, 4, 6, 0, 1,   1,  0,  2,  0,  1, 0});
    tbl.push_back('{8,  1, 1, 3, 2, 1,   1,  4,  6,  0,  1, 0});
    tbl.push_back('{10, 0,-1,-1,-1,-1,   1,  5,  7,  0,  1, 0});
    tbl.push_back('{11, 1, 0, 4, 0, 0,   0, -1, -1, -1,  1, 0});
    tbl.push_back('{12, 1, 1, 5, 1, 0,   1,  0,  4,  1,  1, 0});
    tbl.push_back('{14, 1, 3, 7, 3, 0,   1,  2,  6,  1,  1, 0});
    tbl.push_back('{15, 0,-1,-1,-1,-1,   1,  3,  7,  1,  1, 0});
    tbl.push_back('{16, 0,-1,-1,-1,-1,   0, -1, -1, -1,  0, 1});
    tbl.push_back('{17, 0,-1,-1,-1,-1,   0, -1, -1, -1,  0, 0});

    rst3 = 1'b1; rst9 = 1'b1; rst4 = 1'b1;
    b3.start = 1'b0; b9.start = 1'b0; b4.start = 1'b0;
    b3.load_idx = '0; b9.load_idx = '0; b4.load_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    chk("rst_busy", b3.busy, 0);
    chk("rst_done", b3.done, 0);
    chk("rst_rd_en", b3.rd_en, 0);
    chk("rst_wr_en", b3.wr_en, 0);
    chk("rst_rd_adr_b", b3.rd_adr_b, 0);
    chk("rst_twiddle", b3.twiddle_adr, 0);
    chk("rst_wr_bank", b3.wr_bank, 0);
    chk("rst_wr_adr_a", b9.wr_adr_a, 0);
    chk("rst_load_adr", b9.load_adr, 0);
    chk("result_bank3", b3.result_bank, 1);
    chk("result_bank9", b9.result_bank, 1);
    chk("result_bank4", b4.result_bank, 0);
    rst3 = 1'b0; rst9 = 1'b0;

    // Table-driven sequence with ignored start pulses at cycles 3 and 9.
    @(posedge clk); #1;
    b3.start = 1'b1;
    ti = 0; ndone = 0; dcyc = -1;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(posedge clk); #1;
      b3.start = (cyc == 3 || cyc == 9);
      if (b3.done) begin ndone++; dcyc = cyc; end
      if (ti < tbl.size() && tbl[ti].cyc == cyc) begin
        chk($sformatf("c%0d_rd_en", cyc), b3.rd_en, tbl[ti].rd_en);
        if (tbl[ti].a >= 0) begin
          chk($sformatf("c%0d_rd_adr_a", cyc), b3.rd_adr_a, tbl[ti].a);
          chk($sformatf("c%0d_rd_adr_b", cyc), b3.rd_adr_b, tbl[ti].b);
          chk($sformatf("c%0d_twiddle", cyc), b3.twiddle_adr, tbl[ti].tw);
          chk($sformatf("c%0d_rd_bank", cyc), b3.rd_bank, tbl[ti].rd_bank);
        end
        chk($sformatf("c%0d_wr_en", cyc), b3.wr_en, tbl[ti].wr_en);
        if (tbl[ti].wa >= 0) begin
          chk($sformatf("c%0d_wr_adr_a", cyc), b3.wr_adr_a, tbl[ti].wa);
          chk($sformatf("c%0d_wr_adr_b", cyc), b3.wr_adr_b, tbl[ti].wb);
          chk($sformatf("c%0d_wr_bank", cyc), b3.wr_bank, tbl[ti].wr_bank);
        end
        chk($sformatf("c%0d_busy", cyc), b3.busy, tbl[ti].busy);
        chk($sformatf("c%0d_done", cyc), b3.done, tbl[ti].done);
        ti++;
      end
    end
    chk("seq_done_count", ndone, 1);
    chk("seq_done_cycle", dcyc, 16);

    // Reset during stage 1.
    b3.start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      b3.start = 1'b0;
      if (cyc == 8) begin
        chk("pre_rst_wr_en", b3.wr_en, 1);
        rst3 = 1'b1;
      end
    end
    @(posedge clk); #1;
    rst3 = 1'b0;
    chk("post_rst_busy", b3.busy, 0);
    chk("post_rst_rd_en", b3.rd_en, 0);
    chk("post_rst_wr_en", b3.wr_en, 0);
    chk("post_rst_done", b3.done, 0);
    @(posedge clk); #1;
    chk("post_rst_idle_busy", b3.busy, 0);
    chk("post_rst_idle_done", b3.done, 0);

    // Fresh run after reset: full 15-cycle transform.
    b3.start = 1'b1;
    dcyc = -1; nbusy = 0; nwr = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      b3.start = 1'b0;
      nbusy += int'(b3.busy);
      nwr   += int'(b3.wr_en);
      if (b3.done) begin dcyc = cyc; break; end
    end
    chk("rerun_done_cycle", dcyc, 16);
    chk("rerun_busy_cycles", nbusy, 15);
    chk("rerun_wr_count", nwr, 12);

    // start held through done: back-to-back transforms.
    b3.start = 1'b1;
    dcyc = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (b3.done) begin dcyc = cyc; break; end
    end
    chk("held_done_cycle", dcyc, 16);
    @(posedge clk); #1;
    b3.start = 1'b0;
    chk("b2b_rd_en", b3.rd_en, 1);
    chk("b2b_busy", b3.busy, 1);
    chk("b2b_rd_adr_b", b3.rd_adr_b, 1);
    dcyc = -1;
    for (int cyc = 18; cyc <= 80; cyc++) begin
      @(posedge clk); #1;
      if (b3.done) begin dcyc = cyc; break; end
    end
    chk("b2b_done_cycle", dcyc, 32);

    // Default build: full-length timing.
    b9.start = 1'b1;
    dcyc = -1; nbusy = 0; nwr = 0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(posedge clk); #1;
      b9.start = 1'b0;
      nbusy += int'(b9.busy);
      nwr   += int'(b9.wr_en);
      if (b9.done) begin dcyc = cyc; break; end
    end
    chk("def_done_cycle", dcyc, 2314);
    chk("def_busy_cycles", nbusy, 2313);
    chk("def_wr_count", nwr, 2304);

    // Load address mapping on the default build.
    b9.load_idx = 9'd1;
    @(posedge clk); #1;
    b9.load_idx = 9'd3;
    chk("load_idx1", b9.load_adr, ref_load(1, 9));
    @(posedge clk); #1;
    chk("load_idx3", b9.load_adr, ref_load(3, 9));

    // Randomized traffic against the schedule model.
    p_rst = 1; p_start = 0; p_idx = 0;
    rt = 0; exp_done = 0; exp_load = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (p_rst != 0) begin
        rt = 0; exp_done = 0; exp_load = 0;
      end else begin
        exp_load = ref_load(p_idx, L4);
        if (rt == 0) begin
          exp_done = 0;
          if (p_start != 0) rt = 1;
        end else if (rt == T4) begin
          rt = 0; exp_done = 1;
        end else begin
          rt++; exp_done = 0;
        end
      end
      chk("rnd_busy", b4.busy, (rt != 0) ? 1 : 0);
      chk("rnd_done", b4.done, exp_done);
      chk("rnd_load_adr", b4.load_adr, exp_load);
      sched(rt, en, j, s);
      chk("rnd_rd_en", b4.rd_en, en);
      if (en != 0) begin
        ja = 2 * j;
        chk("rnd_rd_adr_a", b4.rd_adr_a, rot(ja, s, L4));
        chk("rnd_rd_adr_b", b4.rd_adr_b, rot(ja + 1, s, L4));
        chk("rnd_twiddle", b4.twiddle_adr, (j >> (L4 - 1 - s)) << (L4 - 1 - s));
        chk("rnd_rd_bank", b4.rd_bank, s % 2);
      end
      if (rt != 0) sched(rt - LAT4, en, j, s);
      else         en = 0;
      chk("rnd_wr_en", b4.wr_en, en);
      if (en != 0) begin
        ja = 2 * j;
        chk("rnd_wr_adr_a", b4.wr_adr_a, rot(ja, s, L4));
        chk("rnd_wr_adr_b", b4.wr_adr_b, rot(ja + 1, s, L4));
        chk("rnd_wr_bank", b4.wr_bank, 1 - (s % 2));
      end
      p_start = ($urandom_range(0, 9) == 0) ? 1 : 0;
      p_rst   = ($urandom_range(0, 299) == 0) ? 1 : 0;
      p_idx   = int'($urandom_range(0, 15));
      b4.start    = (p_start != 0);
      rst4        = (p_rst != 0);
      b4.load_idx = 4'(p_idx);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
